ext_periph_obi_demux: RTL and testbench
=======================================

Name: ext_periph_obi_demux

Overview:
- Parametrised OBI demultiplexer between the X-HEEP external peripheral port and NSLAVE external MMIO peripherals.
- Address rules are parameter arrays, replacing the fixed two-entry rule set.
- Tracks outstanding transactions so read responses return to the master in order.
- Answers unmapped accesses from an internal error slave, and records the first failing address plus an error count.

Parameters:
- NSLAVE, 2, number of downstream peripherals (1..16).
- START_ADDR, {32'h0000_1000, 32'h0000_0000}, packed NSLAVE x 32-bit rule start addresses (inclusive); index i at bits [32i+31:32i].
- END_ADDR, {32'h0000_2000, 32'h0000_1000}, packed NSLAVE x 32-bit rule end addresses (exclusive).
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions (1..15).
- ERR_RDATA, 32'hBADC_AB1E, rdata returned for unmapped accesses.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  master request
- gnt_o  out  1  master grant
- addr_i  in  32  master address
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  master response valid
- rdata_o  out  32  master read data
- slv_req_o  out  NSLAVE  per-slave request
- slv_gnt_i  in  NSLAVE  per-slave grant
- slv_addr_o  out  32  broadcast address
- slv_we_o  out  1  broadcast write enable
- slv_be_o  out  4  broadcast byte enables
- slv_wdata_o  out  32  broadcast write data
- slv_rvalid_i  in  NSLAVE  per-slave response valid
- slv_rdata_i  in  32*NSLAVE  per-slave read data
- err_o  out  1  sticky unmapped-access flag
- err_addr_o  out  32  address of the first unmapped access since clear
- err_cnt_o  out  8  unmapped-access count, saturating at 255
- err_clr_i  in  1  clears err_o, err_addr_o and err_cnt_o

Behaviour:
- Decode: combinational. Target = lowest index i with START_ADDR[i] <= addr_i < END_ADDR[i]. No match gives target ERR (internal index NSLAVE). Rules with START >= END never match.
- State registers: cnt (0..MAX_OUTSTANDING), cur_tgt (0..NSLAVE), err_pend (1 bit).
- Issue condition: req_i && cnt < MAX_OUTSTANDING && (cnt == 0 || target == cur_tgt). Otherwise all slv_req_o = 0 and gnt_o = 0 (stall). This enforces in-order responses across slaves.
- Mapped target: when the issue condition holds, slv_req_o[target] = 1 and gnt_o = slv_gnt_i[target], both combinational. Broadcast outputs mirror the master inputs at all times.
- ERR target: when the issue condition holds, gnt_o = 1 in the same cycle and no slv_req_o is asserted. err_pend is set, so rvalid_o = 1 and rdata_o = ERR_RDATA in the next cycle (latency 1). Consecutive ERR accesses produce back-to-back responses.
- Response path: rvalid_o = (cnt != 0 && cur_tgt < NSLAVE && slv_rvalid_i[cur_tgt]) || err_pend. rdata_o = slv_rdata_i[cur_tgt] or ERR_RDATA. rdata_o = 0 when rvalid_o = 0.
- Ignored responses: slv_rvalid_i from a non-current slave, or while cnt == 0, is ignored.
- Counter: on grant, cnt += 1 and cur_tgt <= target. On response, cnt -= 1. Grant and response in the same cycle leave cnt unchanged. cnt never exceeds MAX_OUTSTANDING and never underflows.
- Error log: on an ERR grant, err_o <= 1 and err_cnt_o saturating-increments. err_addr_o is captured only if err_o was 0.
- err_clr_i has priority over a simultaneous ERR grant: the log is cleared and that access is not recorded. The ERR response is still returned.
- Reset: gnt_o, rvalid_o, slv_req_o and err_o = 0; err_addr_o, err_cnt_o and rdata_o = 0; cnt = 0, cur_tgt = 0, err_pend = 0. Responses for transactions granted before reset are dropped, because cnt == 0.

Test Plan:
- Read 0x0000_0010 with slv_gnt_i[0] = 1 and slv_rvalid_i[0] = 1 two cycles later with rdata 0x1234_5678 -> slv_req_o = 2'b01, gnt_o in the same cycle, rvalid_o = 1 and rdata_o = 0x1234_5678 exactly once.
- Four back-to-back grants to slave 1 with responses held off -> cnt = 4 and the fifth request stalls (gnt_o = 0). The first response in the same cycle as the fifth request -> fifth request granted, cnt stays 4.
- Request to slave 1 issued while one slave-0 transaction is outstanding -> slv_req_o = 0 until the slave-0 response arrives, then the request is issued in that same cycle.
- Read 0x0000_5000 (unmapped) -> gnt_o = 1 in the same cycle, rvalid_o = 1 with rdata_o = 0xBADC_AB1E in the next cycle, err_o = 1, err_addr_o = 0x0000_5000, err_cnt_o = 1. A second unmapped access at 0x6000 -> err_cnt_o = 2, err_addr_o unchanged. Then err_clr_i -> all error outputs 0.
- 300 unmapped accesses -> err_cnt_o saturates at 255.
- Assert rst_i with 2 transactions outstanding, then drive slv_rvalid_i after reset -> rvalid_o stays 0 and cnt = 0.

Source files
------------

// File: rtl/ext_periph_obi_demux.sv
// ext_periph_obi_demux
//   OBI demultiplexer from the X-HEEP external peripheral port to NSLAVE
//   MMIO peripherals. Address rules come from the START_ADDR/END_ADDR
//   parameter arrays. Unmapped accesses are answered by an internal error
//   slave, which also logs the first failing address and a saturating count.
//   Issue is held back whenever a new target differs from the one that still
//   has transactions outstanding, so read data always returns in order.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i/rvalid_o/rdata_o   master side
//   slv_req_o/slv_gnt_i   per-slave handshake
//   slv_addr_o/slv_we_o/slv_be_o/slv_wdata_o   broadcast request fields
//   slv_rvalid_i/slv_rdata_i   per-slave responses (rdata packed 32*NSLAVE)
//   err_o/err_addr_o/err_cnt_o/err_clr_i   unmapped-access log and clear

module ext_periph_obi_demux #(
    parameter int unsigned                 NSLAVE          = 2,
    parameter logic [NSLAVE*32-1:0]        START_ADDR      = {32'h0000_1000, 32'h0000_0000},
    parameter logic [NSLAVE*32-1:0]        END_ADDR        = {32'h0000_2000, 32'h0000_1000},
    parameter int unsigned                 MAX_OUTSTANDING = 4,
    parameter logic [31:0]                 ERR_RDATA       = 32'hBADC_AB1E
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [31:0]            addr_i,
    input  logic                   we_i,
    input  logic [3:0]             be_i,
    input  logic [31:0]            wdata_i,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    output logic [NSLAVE-1:0]      slv_req_o,
    input  logic [NSLAVE-1:0]      slv_gnt_i,
    output logic [31:0]            slv_addr_o,
    output logic                   slv_we_o,
    output logic [3:0]             slv_be_o,
    output logic [31:0]            slv_wdata_o,
    input  logic [NSLAVE-1:0]      slv_rvalid_i,
    input  logic [32*NSLAVE-1:0]   slv_rdata_i,
    output logic                   err_o,
    output logic [31:0]            err_addr_o,
    output logic [7:0]             err_cnt_o,
    input  logic                   err_clr_i
);

    localparam int TW = $clog2(NSLAVE + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TW-1:0] ERR_TGT = TW'(NSLAVE);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    logic [TW-1:0] cur_tgt_q, cur_tgt_d;
    logic          err_pend_q, err_pend_d;
    logic          err_q;
    logic [31:0]   err_addr_q;
    logic [7:0]    err_cnt_q;

    logic [TW-1:0] tgt;
    logic          hit;
    logic          tgt_gnt;
    logic          sel_rv;
    logic [31:0]   sel_rd;
    logic          rsp;
    logic          issue;
    logic          is_err;
    logic          gnt;

    // Lowest matching rule wins; empty rules (START >= END) cannot match.
    always_comb begin
        tgt = ERR_TGT;
        hit = 1'b0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (!hit && addr_i >= START_ADDR[32*i +: 32] && addr_i < END_ADDR[32*i +: 32]) begin
                tgt = TW'(i);
                hit = 1'b1;
            end
        end
    end

    // Mux by compare so the ERR index never indexes past the slave arrays.
    always_comb begin
        tgt_gnt = 1'b0;
        sel_rv  = 1'b0;
        sel_rd  = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (tgt == TW'(i))       tgt_gnt = slv_gnt_i[i];
            if (cur_tgt_q == TW'(i)) begin
                sel_rv = slv_rvalid_i[i];
                sel_rd = slv_rdata_i[32*i +: 32];
            end
        end
    end

    // A response retiring this cycle frees its slot and, if it was the last
    // one, lets a different target issue in the same cycle.
    assign rsp     = !rst_i && ((cnt_q != '0 && sel_rv) || err_pend_q);
    assign cnt_eff = cnt_q - CW'(rsp);
    assign is_err  = (tgt == ERR_TGT);
    assign issue   = req_i && !rst_i && (cnt_eff < MAX_CNT) &&
                     (cnt_eff == '0 || tgt == cur_tgt_q);
    assign gnt     = issue && (is_err || tgt_gnt);

    always_comb begin
        slv_req_o = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            slv_req_o[i] = issue && (tgt == TW'(i));
        end
    end

    assign gnt_o       = gnt;
    assign rvalid_o    = rsp;
    assign rdata_o     = !rsp ? 32'h0 : (err_pend_q ? ERR_RDATA : sel_rd);
    assign slv_addr_o  = addr_i;
    assign slv_we_o    = we_i;
    assign slv_be_o    = be_i;
    assign slv_wdata_o = wdata_i;

    assign cnt_d      = cnt_eff + CW'(gnt);
    assign cur_tgt_d  = gnt ? tgt : cur_tgt_q;
    assign err_pend_d = gnt && is_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            cur_tgt_q  <= '0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            cur_tgt_q  <= cur_tgt_d;
            err_pend_q <= err_pend_d;
            // Clear wins over a same-cycle error grant; that access goes unlogged.
            if (err_clr_i) begin
                err_q      <= 1'b0;
                err_addr_q <= '0;
                err_cnt_q  <= '0;
            end else if (gnt && is_err) begin
                err_q <= 1'b1;
                if (!err_q)              err_addr_q <= addr_i;
                if (err_cnt_q != 8'hFF)  err_cnt_q  <= err_cnt_q + 8'd1;
            end
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_ext_periph_obi_demux.sv
module tb_ext_periph_obi_demux;

    localparam logic [31:0] E = 32'hBADC_AB1E;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [1:0]  sg;
        logic [1:0]  srv;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        clr;
        logic        gnt;
        logic [1:0]  sreq;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  ecnt;
        logic [31:0] eaddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, gnt, we, rvalid, clr;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic [1:0]  sreq, sgnt, srv;
    logic [31:0] saddr, swdata;
    logic        swe;
    logic [3:0]  sbe;
    logic [31:0] rd0, rd1;
    logic        err;
    logic [31:0] eaddr;
    logic [7:0]  ecnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ext_periph_obi_demux dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid), .rdata_o(rdata),
        .slv_req_o(sreq), .slv_gnt_i(sgnt),
        .slv_addr_o(saddr), .slv_we_o(swe), .slv_be_o(sbe), .slv_wdata_o(swdata),
        .slv_rvalid_i(srv), .slv_rdata_i({rd1, rd0}),
        .err_o(err), .err_addr_o(eaddr), .err_cnt_o(ecnt), .err_clr_i(clr)
    );

    function automatic vec_t mk(logic rq, logic [31:0] a, logic [1:0] g, logic [1:0] v,
                                logic [31:0] r0, logic [31:0] r1, logic c,
                                logic eg, logic [1:0] es, logic ev, logic [31:0] ed,
                                logic ee, logic [7:0] ec, logic [31:0] ea);
        vec_t t;
        t.req = rq; t.addr = a; t.sg = g; t.srv = v; t.rd0 = r0; t.rd1 = r1; t.clr = c;
        t.gnt = eg; t.sreq = es; t.rv = ev; t.rdata = ed; t.err = ee; t.ecnt = ec; t.eaddr = ea;
        return t;
    endfunction

    task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one vector just after a rising edge, compare on the falling edge.
    task automatic run(string nm, vec_t v);
        req = v.req; addr = v.addr; sgnt = v.sg; srv = v.srv;
        rd0 = v.rd0; rd1 = v.rd1; clr = v.clr;
        we = addr[2]; be = addr[7:4]; wdata = ~addr;
        @(negedge clk);
        chk(nm, {3'b0, gnt, sreq, rvalid, rdata, err, ecnt, eaddr},
                {3'b0, v.gnt, v.sreq, v.rv, v.rdata, v.err, v.ecnt, v.eaddr});
        if ({saddr, swe, sbe, swdata} !== {addr, we, be, wdata}) begin
            n_bad++;
            $display("FAIL %s bcast: got %h expected %h", nm, {saddr, swe, sbe, swdata}, {addr, we, be, wdata});
        end
        n_vec++;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    int   miss;

    initial begin
        rst = 1'b1; req = 0; addr = 0; we = 0; be = 0; wdata = 0;
        sgnt = 0; srv = 0; rd0 = 0; rd1 = 0; clr = 0;
        repeat (2) @(posedge clk);
        #1;
        // reset state: a request during reset must not be issued
        run("reset", mk(1, 32'h10, 2'b01, 2'b01, 32'h1, 0, 0,  0, 2'b00, 0, 0, 0, 0, 0));
        rst = 1'b0;

        //            req addr          sg     srv    rd0           rd1          clr  gnt sreq   rv rdata         err ecnt eaddr
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b00, 0,            0,            0,  0, 2'b00, 0, 0,            0, 0, 0));
        // single read to slave 0
        tbl.push_back(mk(1, 32'h10,     2'b01, 2'b00, 0,            0,            0,  1, 2'b01, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b00, 0,            0,            0,  0, 2'b00, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b01, 32'h12345678, 0,            0,  0, 2'b00, 1, 32'h12345678, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b01, 32'h12345678, 0,            0,  0, 2'b00, 0, 0,            0, 0, 0));
        // four outstanding to slave 1, fifth stalls, then granted alongside first response
        tbl.push_back(mk(1, 32'h1004,   2'b10, 2'b00, 0,            0,            0,  1, 2'b10, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h1004,   2'b10, 2'b00, 0,            0,            0,  1, 2'b10, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h1004,   2'b10, 2'b00, 0,            0,            0,  1, 2'b10, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h1004,   2'b10, 2'b00, 0,            0,            0,  1, 2'b10, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h1004,   2'b10, 2'b00, 0,            0,            0,  0, 2'b00, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h1004,   2'b10, 2'b10, 0,            32'hAAAA0001, 0,  1, 2'b10, 1, 32'hAAAA0001, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b10, 0,            32'hAAAA0002, 0,  0, 2'b00, 1, 32'hAAAA0002, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b10, 0,            32'hAAAA0003, 0,  0, 2'b00, 1, 32'hAAAA0003, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b10, 0,            32'hAAAA0004, 0,  0, 2'b00, 1, 32'hAAAA0004, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b10, 0,            32'hAAAA0005, 0,  0, 2'b00, 1, 32'hAAAA0005, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b10, 0,            32'hAAAA0006, 0,  0, 2'b00, 0, 0,            0, 0, 0));
        // target switch waits for slave 0 to drain, issues in the draining cycle
        tbl.push_back(mk(1, 32'h20,     2'b01, 2'b00, 0,            0,            0,  1, 2'b01, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h1008,   2'b10, 2'b10, 0,            32'h66,       0,  0, 2'b00, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h1008,   2'b10, 2'b01, 32'h55,       0,            0,  1, 2'b10, 1, 32'h55,       0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b10, 0,            32'h66,       0,  0, 2'b00, 1, 32'h66,       0, 0, 0));
        // slave wait state: request held without grant
        tbl.push_back(mk(1, 32'h30,     2'b00, 2'b00, 0,            0,            0,  0, 2'b01, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h30,     2'b01, 2'b00, 0,            0,            0,  1, 2'b01, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b01, 32'h77,       0,            0,  0, 2'b00, 1, 32'h77,       0, 0, 0));
        // unmapped accesses and error log
        tbl.push_back(mk(1, 32'h5000,   2'b11, 2'b00, 0,            0,            0,  1, 2'b00, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h6000,   2'b11, 2'b00, 0,            0,            0,  1, 2'b00, 1, E,            1, 1, 32'h5000));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b00, 0,            0,            0,  0, 2'b00, 1, E,            1, 2, 32'h5000));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b00, 0,            0,            1,  0, 2'b00, 0, 0,            1, 2, 32'h5000));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b00, 0,            0,            0,  0, 2'b00, 0, 0,            0, 0, 0));
        // rule boundaries: 0x1000 -> slave 1, 0x2000 unmapped, 0xFFC -> slave 0
        tbl.push_back(mk(1, 32'h1000,   2'b10, 2'b00, 0,            0,            0,  1, 2'b10, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h2000,   2'b00, 2'b10, 0,            32'h99,       0,  1, 2'b00, 1, 32'h99,       0, 0, 0));
        tbl.push_back(mk(1, 32'hFFC,    2'b01, 2'b00, 0,            0,            1,  1, 2'b01, 1, E,            1, 1, 32'h2000));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b01, 32'hAB,       0,            0,  0, 2'b00, 1, 32'hAB,       0, 0, 0));
        // clear beats a same-cycle error grant; response still returned
        tbl.push_back(mk(1, 32'h7000,   2'b00, 2'b00, 0,            0,            1,  1, 2'b00, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 32'h0,      2'b00, 2'b00, 0,            0,            0,  0, 2'b00, 1, E,            0, 0, 0));

        foreach (tbl[i]) run($sformatf("v%0d", i), tbl[i]);

        // saturation: 300 back-to-back unmapped accesses
        req = 1; addr = 32'h8000; sgnt = 0; srv = 0; clr = 0;
        miss = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!gnt) miss++;
            if (k == 254) chk("sat254", {72'h0, ecnt}, {72'h0, 8'd254});
            @(posedge clk);
            #1;
        end
        chk("sat_gnt", 80'(miss), 80'(0));
        run("sat255", mk(0, 0, 2'b00, 2'b00, 0, 0, 0,  0, 2'b00, 1, E, 1, 8'd255, 32'h8000));
        run("sat_clr", mk(0, 0, 2'b00, 2'b00, 0, 0, 1,  0, 2'b00, 0, 0, 1, 8'd255, 32'h8000));

        // reset with two slave-0 transactions outstanding
        run("pre0", mk(1, 32'h40, 2'b01, 2'b00, 0, 0, 0,  1, 2'b01, 0, 0, 0, 0, 0));
        run("pre1", mk(1, 32'h44, 2'b01, 2'b00, 0, 0, 0,  1, 2'b01, 0, 0, 0, 0, 0));
        rst = 1'b1;
        run("rst_mid", mk(1, 32'h48, 2'b01, 2'b01, 32'hDEAD, 0, 0,  0, 2'b00, 0, 0, 0, 0, 0));
        rst = 1'b0;
        run("drop0", mk(0, 0, 2'b00, 2'b01, 32'hDEAD, 0, 0,  0, 2'b00, 0, 0, 0, 0, 0));
        run("drop1", mk(0, 0, 2'b00, 2'b01, 32'hDEAD, 0, 0,  0, 2'b00, 0, 0, 0, 0, 0));
        run("post_req", mk(1, 32'h1010, 2'b10, 2'b00, 0, 0, 0,  1, 2'b10, 0, 0, 0, 0, 0));
        run("post_rsp", mk(0, 0, 2'b00, 2'b10, 0, 32'hC0DE, 0,  0, 2'b00, 1, 32'hC0DE, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
